// File: rtl/ahb_slave_mem.sv
// AHB-Lite word-organised memory slave with configurable wait states and
// ERROR responses for illegal size, misalignment and out-of-window addresses.
module ahb_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_WORDS   = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int          AW         = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES  = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [3:0]    cnt_r, cnt_s;
  logic [31:0]   addr_r, addr_s;
  logic [2:0]    size_r, size_s;
  logic          write_r, write_s;
  logic          pend_r, pend_s;
  logic          hready_s;
  logic [1:0]    hresp_s;
  logic [31:0]   hrdata_s;
  logic [31:0]   mem_r [MEM_WORDS];

  logic          accept_s;
  logic          illegal_s;
  logic          commit_s;
  logic [31:0]   offset_s;
  logic [31:0]   cur_off_s;
  logic [AW-1:0] acc_idx_s;
  logic [AW-1:0] cur_idx_s;
  logic [AW-1:0] rd_idx_s;
  logic [31:0]   wr_data_s;
  logic [31:0]   rd_word_s;
  logic          unused_s;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      3'd0:    lane_mask = 4'b0001 << lo;
      3'd1:    lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      3'd2:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      3'd0:    misaligned = 1'b0;
      3'd1:    misaligned = lo[0];
      3'd2:    misaligned = (lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      merge_lanes[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
  endfunction

  // Address decode, legality and write-merge datapath
  always_comb begin
    accept_s  = hsel & hready_in & htrans[1] & ((state_r == ST_IDLE) | (state_r == ST_ERR2));
    offset_s  = haddr - BASE_ADDR;
    illegal_s = (hsize > 3'd2) | misaligned(hsize, haddr[1:0]) |
                (haddr < BASE_ADDR) | (offset_s >= MEM_BYTES);
    acc_idx_s = offset_s[AW+1:2];
    cur_off_s = addr_r - BASE_ADDR;
    cur_idx_s = cur_off_s[AW+1:2];
    // IDLE with a pending legal transfer is always the completing OKAY cycle
    commit_s  = (state_r == ST_IDLE) & pend_r & write_r;
    wr_data_s = merge_lanes(mem_r[cur_idx_s], hwdata, lane_mask(size_r, addr_r[1:0]));
  end

  // FSM next state and address-phase capture
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    size_s  = size_r;
    write_s = write_r;
    pend_s  = pend_r;
    case (state_r)
      ST_IDLE, ST_ERR2: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
        pend_s  = 1'b0;
        if (accept_s) begin
          addr_s  = haddr;
          size_s  = hsize;
          write_s = hwrite;
          if (illegal_s) begin
            state_s = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            pend_s  = 1'b1;
            state_s = ST_WAIT;
            cnt_s   = WAIT_LOAD;
          end else begin
            pend_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_ERR1: begin
        state_s = ST_ERR2;
        pend_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        pend_s  = 1'b0;
      end
    endcase
  end

  // Output decode for the next cycle; reads forward a write committing on the same edge
  always_comb begin
    hready_s  = ~((state_s == ST_WAIT) | (state_s == ST_ERR1));
    hresp_s   = ((state_s == ST_ERR1) | (state_s == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
    rd_idx_s  = (state_r == ST_WAIT) ? cur_idx_s : acc_idx_s;
    rd_word_s = (commit_s && (rd_idx_s == cur_idx_s)) ? wr_data_s : mem_r[rd_idx_s];
    if ((state_s == ST_IDLE) && pend_s && !write_s) begin
      hrdata_s = rd_word_s;
    end else begin
      hrdata_s = 32'h0000_0000;
    end
  end

  // Control state and registered bus outputs
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      addr_r     <= 32'h0000_0000;
      size_r     <= 3'd0;
      write_r    <= 1'b0;
      pend_r     <= 1'b0;
      hready_out <= 1'b1;
      hresp      <= RESP_OKAY;
      hrdata     <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      addr_r     <= addr_s;
      size_r     <= size_s;
      write_r    <= write_s;
      pend_r     <= pend_s;
      hready_out <= hready_s;
      hresp      <= hresp_s;
      hrdata     <= hrdata_s;
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge hclk) begin
    if (commit_s) begin
      mem_r[cur_idx_s] <= wr_data_s;
    end
  end

  assign unused_s = ^{hburst, htrans[0], offset_s[31:AW+2], offset_s[1:0],
                      cur_off_s[31:AW+2], cur_off_s[1:0]};

endmodule
